// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: Funct3 encodings, FSM state
// type, access-size decode and the spanning rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Unknown encodings fall back to a full word access.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        lsu_size_t sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Byte-lane mask of an access that starts at lane 0.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3_size(f3))
            SZ_B:    m = 4'b0001;
            SZ_H:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // True when the access touches bytes in the following word.
    function automatic logic spans(input logic [2:0] f3, input logic [1:0] off);
        logic s;
        case (f3_size(f3))
            SZ_B:    s = 1'b0;
            SZ_H:    s = (off == 2'd3);
            default: s = (off != 2'd0);
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
// Stores: lane mask and data shifted to the byte offset; sel_hi picks the
// upper (second word) half of a split access.
// Loads: the two captured words are shifted down by the byte offset and the
// result is sign- or zero-extended according to Funct3.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic              sel_hi,
    input  logic [DATA_W-1:0] wd,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    output logic [3:0]        wr_mask,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]          mask_wide;
    logic [2*DATA_W-1:0] data_wide;
    logic [DATA_W-1:0]   ld_x;
    logic [4:0]          shamt;

    // Narrow loads: signed extension for LB/LH, zero extension for LBU/LHU.
    function automatic logic [DATA_W-1:0] extend_load(input logic [2:0] f3,
                                                       input logic [DATA_W-1:0] x);
        logic signed [7:0]        xb;
        logic signed [15:0]       xh;
        logic signed [DATA_W-1:0] r;
        xb = x[7:0];
        xh = x[15:0];
        case (f3)
            F3_B:    r = xb;
            F3_H:    r = xh;
            F3_BU:   r = {{(DATA_W-8){1'b0}}, x[7:0]};
            F3_HU:   r = {{(DATA_W-16){1'b0}}, x[15:0]};
            default: r = x;
        endcase
        return r;
    endfunction

    // Shift mask and data into place, then pick the half for this cycle.
    always_comb begin
        shamt     = {off, 3'b000};
        mask_wide = {4'b0000, size_mask(funct3)} << off;
        data_wide = {{DATA_W{1'b0}}, wd} << shamt;
        ld_x      = DATA_W'({hi, lo} >> shamt);
        wr_mask   = sel_hi ? mask_wide[7:4] : mask_wide[3:0];
        wdata     = sel_hi ? data_wide[2*DATA_W-1:DATA_W] : data_wide[DATA_W-1:0];
        ld_data   = extend_load(funct3, ld_x);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the EX/MEM register and a word-organised data
// memory. Accepts one byte-addressed access at a time (valid/ready), performs
// one or two word-aligned memory cycles and returns a one-cycle response.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- spanning accesses are not
// split but answered immediately with misalign=1.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     rd,
    output logic                  misalign,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic                  mem_re,
    output logic [3:0]            mem_wr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    lsu_state_t state, state_d;

    // Latched request
    logic [DM_ADDRESS-1:0] a_q;
    logic [DATA_W-1:0]     wd_q;
    logic [2:0]            f3_q;
    logic                  is_load_q;
    logic [DATA_W-1:0]     lo_q;

    // Output holding registers
    logic [DM_ADDRESS-1:0] addr_hold;
    logic [DATA_W-1:0]     wdata_hold;
    logic [DATA_W-1:0]     rd_q;

    logic                  accept;
    logic                  split;
    logic                  in_acc;
    logic                  sel_hi;
    logic                  finish_acc;
    logic [DM_ADDRESS-3:0] word_hi;
    logic [DM_ADDRESS-1:0] cur_addr;
    logic [DATA_W-1:0]     lo_in;
    logic [DATA_W-1:0]     hi_in;
    logic [3:0]            al_mask;
    logic [DATA_W-1:0]     al_wdata;
    logic [DATA_W-1:0]     al_ld;

    assign req_ready  = (state == IDLE) && !reset;
    assign accept     = req_valid && req_ready && (MemRead || MemWrite);
    assign split      = spans(f3_q, a_q[1:0]);
    assign in_acc     = (state == ACC1) || (state == ACC2);
    assign sel_hi     = (state == ACC2);
    assign finish_acc = ((state == ACC1) && !split) || (state == ACC2);

    // Second word wraps around the top of the data memory.
    assign word_hi  = a_q[DM_ADDRESS-1:2] + (DM_ADDRESS-2)'(1);
    assign cur_addr = sel_hi ? {word_hi, 2'b00} : {a_q[DM_ADDRESS-1:2], 2'b00};

    // The low word comes straight from memory in ACC1 and from lo_q in ACC2.
    assign lo_in = (state == ACC1) ? mem_rdata : lo_q;
    assign hi_in = (state == ACC2) ? mem_rdata : '0;

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .funct3  (f3_q),
        .off     (a_q[1:0]),
        .sel_hi  (sel_hi),
        .wd      (wd_q),
        .lo      (lo_in),
        .hi      (hi_in),
        .wr_mask (al_mask),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    assign mem_addr   = in_acc ? cur_addr : addr_hold;
    assign mem_wdata  = in_acc ? al_wdata : wdata_hold;
    assign mem_re     = in_acc && is_load_q;
    assign mem_wr     = (in_acc && !is_load_q) ? al_mask : 4'b0000;
    assign resp_valid = (state == RESP);
    assign rd         = rd_q;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misalign = misalign_q && resp_valid;
`else
    assign misalign = 1'b0;
`endif

    // Next-state decode for the access sequence.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = spans(Funct3, a[1:0]) ? RESP : ACC1;
`else
                    state_d = ACC1;
`endif
                end
            end
            ACC1:    state_d = split ? ACC2 : RESP;
            ACC2:    state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Control state and visible outputs; cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_hold  <= '0;
            wdata_hold <= '0;
            rd_q       <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state <= state_d;
            if (in_acc) begin
                addr_hold  <= cur_addr;
                wdata_hold <= al_wdata;
            end
            if (finish_acc) begin
                rd_q <= is_load_q ? al_ld : '0;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            if (accept) begin
                misalign_q <= spans(Funct3, a[1:0]);
                if (spans(Funct3, a[1:0])) begin
                    rd_q <= '0;
                end
            end
`endif
        end
    end

    // Request and first-word capture; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q       <= a;
            wd_q      <= wd;
            f3_q      <= Funct3;
            is_load_q <= MemRead;
        end
        if (state == ACC1) begin
            lo_q <= mem_rdata;
        end
    end

endmodule
